pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 10 +
 rtl/pwm_period_timer.sv | 30 +++
 rtl/pwm_fade_ctrl.sv | 123 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default widths for the PWM fade controller and its period timer.
package pwm_ctrl_pkg;
  localparam int unsigned PWM_W      = 32;
  localparam int unsigned PWM_HOLD_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } fade_state_e;
endpackage

// File: rtl/pwm_period_timer.sv
// Free-running period counter that mirrors the PWM counter and flags each wrap.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         clear_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] step_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;
  logic         wrap;

  assign wrap = !(cnt_q < period_i);
  // The reset gate keeps the tick quiet while held in reset (cnt == period == 0 there).
  assign tick_o = reset_ni & wrap;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clear_i || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + step_i;
    end
  end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade controller: ramps the PWM threshold from start to end, one update per hold window.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int W      = PWM_W,
  parameter int HOLD_W = PWM_HOLD_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [W-1:0]      cfg_period_i,
  input  logic [W-1:0]      cfg_step_i,
  input  logic [W-1:0]      cfg_start_i,
  input  logic [W-1:0]      cfg_end_i,
  input  logic [W-1:0]      cfg_inc_i,
  input  logic [HOLD_W-1:0] cfg_hold_i,
  input  logic              abort_i,
  output logic [W-1:0]      threshold_o,
  output logic [W-1:0]      step_o,
  output logic [W-1:0]      period_counter_o,
  output logic              period_tick_o,
  output logic              busy_o,
  output logic              done_o
);
  fade_state_e       state_q, state_d;
  logic [W-1:0]      thr_q, step_q, per_q, end_q, inc_q, thr_next;
  logic [HOLD_W-1:0] hold_cnt_q, hold_rld_q;
  logic              done_q, accept, tick, upd, hold_dec, fin;

  // One move toward the target, evaluated at W+1 bits so neither direction can wrap.
  function automatic logic [W-1:0] fade_step(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                             input logic [W-1:0] inc);
    logic [W:0] sum;
    logic [W:0] diff;
    sum  = {1'b0, cur} + {1'b0, inc};
    diff = {1'b0, cur} - {1'b0, inc};
    if (inc == '0) return tgt;
    if (tgt > cur) return (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
    return (diff[W] || (diff[W-1:0] <= tgt)) ? tgt : diff[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_sat(input logic [W-1:0] s);
    return (s == '0) ? {{(W-1){1'b0}}, 1'b1} : s;
  endfunction

  assign cfg_ready_o      = (state_q == ST_IDLE);
  assign busy_o           = (state_q == ST_RAMP);
  assign accept           = cfg_valid_i & cfg_ready_o;
  assign threshold_o      = thr_q;
  assign step_o           = step_q;
  assign period_counter_o = per_q;
  assign period_tick_o    = tick;
  assign done_o           = done_q;

  pwm_period_timer #(.W(W)) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (accept),
    .period_i (per_q),
    .step_i   (step_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    upd      = 1'b0;
    hold_dec = 1'b0;
    fin      = 1'b0;
    thr_next = fade_step(thr_q, end_q, inc_q);
    if (state_q == ST_IDLE) begin
      if (cfg_valid_i) state_d = ST_RAMP;
    end else begin
      if (tick) begin
        if (hold_cnt_q != '0) begin
          hold_dec = 1'b1;
        end else begin
          upd = 1'b1;
          fin = (thr_next == end_q);
        end
      end
      // A completing update outranks a simultaneous abort.
      if (fin) begin
        state_d = ST_IDLE;
      end else if (abort_i) begin
        state_d  = ST_IDLE;
        upd      = 1'b0;
        hold_dec = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      thr_q      <= '0;
      step_q     <= {{(W-1){1'b0}}, 1'b1};
      per_q      <= '0;
      end_q      <= '0;
      inc_q      <= '0;
      hold_cnt_q <= '0;
      hold_rld_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (accept) begin
        thr_q      <= cfg_start_i;
        step_q     <= step_sat(cfg_step_i);
        per_q      <= cfg_period_i;
        end_q      <= cfg_end_i;
        inc_q      <= cfg_inc_i;
        hold_cnt_q <= cfg_hold_i;
        hold_rld_q <= cfg_hold_i;
      end else if (upd) begin
        thr_q      <= thr_next;
        hold_cnt_q <= hold_rld_q;
      end else if (hold_dec) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: timer periods, up/down ramps, abort, and edge cases.
module tb_pwm_fade_ctrl;
  localparam int W      = 16;
  localparam int HOLD_W = 8;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [W-1:0]      cfg_period_i, cfg_step_i, cfg_start_i, cfg_end_i, cfg_inc_i;
  logic [HOLD_W-1:0] cfg_hold_i;
  logic              abort_i;
  logic [W-1:0]      threshold_o, step_o, period_counter_o;
  logic              period_tick_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  pwm_fade_ctrl #(.W(W), .HOLD_W(HOLD_W)) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_period_i     (cfg_period_i),
    .cfg_step_i       (cfg_step_i),
    .cfg_start_i      (cfg_start_i),
    .cfg_end_i        (cfg_end_i),
    .cfg_inc_i        (cfg_inc_i),
    .cfg_hold_i       (cfg_hold_i),
    .abort_i          (abort_i),
    .threshold_o      (threshold_o),
    .step_o           (step_o),
    .period_counter_o (period_counter_o),
    .period_tick_o    (period_tick_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Illegal configurations (period + step overflowing W bits) must never be offered.
  always @(posedge clk_i) begin
    if (reset_ni && cfg_valid_i && cfg_ready_o)
      assert (({1'b0, cfg_period_i} + {1'b0, cfg_step_i}) <= {1'b0, {W{1'b1}}})
      else $error("illegal config period=%0d step=%0d", cfg_period_i, cfg_step_i);
  end

  task automatic tick_clk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input int p, input int s, input int st, input int en, input int inc,
                         input int h);
    cfg_period_i = W'(p);
    cfg_step_i   = W'(s);
    cfg_start_i  = W'(st);
    cfg_end_i    = W'(en);
    cfg_inc_i    = W'(inc);
    cfg_hold_i   = HOLD_W'(h);
    cfg_valid_i  = 1'b1;
    tick_clk();
    cfg_valid_i  = 1'b0;
  endtask

  // Counts cycles until period_tick_o is seen, bounded at 100.
  task automatic wait_tick(output int n);
    n = 0;
    while (!period_tick_o && n < 100) begin
      tick_clk();
      n++;
    end
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    tick_clk();
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    #12;
    if (threshold_o !== 16'd0) begin errors++; $display("FAIL rst_thr: got %0d expected 0", threshold_o); end checks++;
    if (step_o !== 16'd1) begin errors++; $display("FAIL rst_step: got %0d expected 1", step_o); end checks++;
    if (period_counter_o !== 16'd0) begin errors++; $display("FAIL rst_per: got %0d expected 0", period_counter_o); end checks++;
    if ({period_tick_o, busy_o, done_o, cfg_ready_o} !== 4'b0001) begin
      errors++; $display("FAIL rst_flags: got %b expected 0001", {period_tick_o, busy_o, done_o, cfg_ready_o});
    end checks++;
    reset_ni = 1'b1;
    tick_clk();
  endtask

  task automatic test_timer();
    int per[3] = '{9, 10, 0};
    int stp[3] = '{1, 3, 1};
    int len[3] = '{10, 5, 1};
    int n;
    for (int i = 0; i < 3; i++) begin
      request(per[i], stp[i], 0, 100, 1, 200);
      wait_tick(n);
      if (n !== len[i] - 1) begin errors++; $display("FAIL timer_first[%0d]: got %0d expected %0d", i, n, len[i] - 1); end checks++;
      tick_clk();
      wait_tick(n);
      if (n + 1 !== len[i]) begin errors++; $display("FAIL timer_gap[%0d]: got %0d expected %0d", i, n + 1, len[i]); end checks++;
      if (threshold_o !== 16'd0) begin errors++; $display("FAIL timer_hold_thr[%0d]: got %0d expected 0", i, threshold_o); end checks++;
      do_abort();
    end
  endtask

  task automatic test_up_ramp();
    int n;
    request(3, 1, 0, 4, 2, 0);
    if ({busy_o, cfg_ready_o} !== 2'b10) begin errors++; $display("FAIL up_busy: got %b expected 10", {busy_o, cfg_ready_o}); end checks++;
    if (threshold_o !== 16'd0) begin errors++; $display("FAIL up_thr0: got %0d expected 0", threshold_o); end checks++;
    wait_tick(n);
    if (n !== 3) begin errors++; $display("FAIL up_tick1: got %0d expected 3", n); end checks++;
    tick_clk();
    if (threshold_o !== 16'd2 || done_o !== 1'b0) begin errors++; $display("FAIL up_thr1: got %0d/%b expected 2/0", threshold_o, done_o); end checks++;
    wait_tick(n);
    tick_clk();
    if (threshold_o !== 16'd4) begin errors++; $display("FAIL up_thr2: got %0d expected 4", threshold_o); end checks++;
    if ({done_o, busy_o} !== 2'b10) begin errors++; $display("FAIL up_done: got %b expected 10", {done_o, busy_o}); end checks++;
    tick_clk();
    if ({done_o, cfg_ready_o} !== 2'b01) begin errors++; $display("FAIL up_done_pulse: got %b expected 01", {done_o, cfg_ready_o}); end checks++;
  endtask

  task automatic test_down_ramp();
    int n;
    int exp_thr[4] = '{10, 6, 6, 3};
    request(3, 1, 10, 3, 4, 1);
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      tick_clk();
      if (threshold_o !== W'(exp_thr[k])) begin errors++; $display("FAIL down_thr[%0d]: got %0d expected %0d", k, threshold_o, exp_thr[k]); end checks++;
      if (done_o !== (k == 3)) begin errors++; $display("FAIL down_done[%0d]: got %b expected %b", k, done_o, (k == 3)); end checks++;
    end
  endtask

  task automatic test_abort();
    int n;
    int pulses = 0;
    request(3, 1, 0, 4, 2, 0);
    wait_tick(n);
    tick_clk();
    do_abort();
    if ({busy_o, cfg_ready_o, done_o} !== 3'b010) begin errors++; $display("FAIL abort_flags: got %b expected 010", {busy_o, cfg_ready_o, done_o}); end checks++;
    if (threshold_o !== 16'd2) begin errors++; $display("FAIL abort_thr: got %0d expected 2", threshold_o); end checks++;
    for (int k = 0; k < 10; k++) begin
      if (done_o) pulses++;
      tick_clk();
    end
    if (pulses !== 0 || threshold_o !== 16'd2) begin errors++; $display("FAIL abort_quiet: got %0d pulses thr %0d expected 0 pulses thr 2", pulses, threshold_o); end checks++;
    // Abort coinciding with the completing tick resolves as completion.
    request(3, 1, 0, 1, 1, 0);
    wait_tick(n);
    do_abort();
    if ({done_o, threshold_o} !== {1'b1, 16'd1}) begin errors++; $display("FAIL abort_vs_done: got %b/%0d expected 1/1", done_o, threshold_o); end checks++;
    tick_clk();
  endtask

  task automatic test_edges();
    int n;
    request(3, 0, 5, 5, 1, 0);
    if (step_o !== 16'd1) begin errors++; $display("FAIL step_zero: got %0d expected 1", step_o); end checks++;
    wait_tick(n);
    tick_clk();
    if ({done_o, busy_o, threshold_o} !== {2'b10, 16'd5}) begin errors++; $display("FAIL start_eq_end: got %b/%0d expected 10/5", {done_o, busy_o}, threshold_o); end checks++;
    request(3, 1, 0, 8, 1, 3);
    request(7, 2, 9, 1, 1, 0);
    if (period_counter_o !== 16'd3 || step_o !== 16'd1 || threshold_o !== 16'd0 || cfg_ready_o !== 1'b0) begin
      errors++; $display("FAIL busy_ignore: got per %0d step %0d thr %0d rdy %b expected 3 1 0 0", period_counter_o, step_o, threshold_o, cfg_ready_o);
    end checks++;
    reset_ni = 1'b0;
    #1;
    if ({threshold_o, step_o, period_counter_o} !== {16'd0, 16'd1, 16'd0}) begin
      errors++; $display("FAIL midramp_rst_regs: got %0d %0d %0d expected 0 1 0", threshold_o, step_o, period_counter_o);
    end checks++;
    if ({period_tick_o, busy_o, done_o, cfg_ready_o} !== 4'b0001) begin
      errors++; $display("FAIL midramp_rst_flags: got %b expected 0001", {period_tick_o, busy_o, done_o, cfg_ready_o});
    end checks++;
    #2;
    reset_ni = 1'b1;
    tick_clk();
  endtask

  initial begin
    cfg_valid_i  = 1'b0;
    abort_i      = 1'b0;
    cfg_period_i = '0;
    cfg_step_i   = '0;
    cfg_start_i  = '0;
    cfg_end_i    = '0;
    cfg_inc_i    = '0;
    cfg_hold_i   = '0;
    test_reset();
    test_timer();
    test_up_ramp();
    test_down_ramp();
    test_abort();
    test_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
